ham_serial_tx: RTL
==================

# ham_serial_tx

Transmit side of the board's Hamming (7,4) link: takes a 4-bit value, encodes it into a 7-bit codeword and shifts it out on a single serial line as a framed bit stream. It can also flip one selected codeword bit to exercise the receiving syndrome decoder. It sits beside the existing decoder/display path. Its `code` output can drive the decoder's 7-bit codeword input directly for loopback tests on the same board.

## Interface
- `BIT_CYCLES`, default 2700: clock cycles per serial bit (10 kbit/s at 27 MHz); legal range ≥ 2.
- `clk` input 1: system clock.
- `rst` input 1: synchronous, active-high reset.
- `in_data` input 4: data nibble d[3:0] to encode.
- `in_valid` input 1: `in_data` valid.
- `in_ready` output 1: block can accept a nibble.
- `inj_pos` input 3: error injection, 0 = none, 1..7 = flip codeword position 1..7; sampled at accept.
- `code` output 7: registered codeword of the last accepted nibble, with any injected error applied.
- `tx` output 1: serial line, idle high.
- `busy` output 1: frame in progress.
- `done` output 1: one-cycle pulse when the stop bit completes.

## Operation
- Codeword layout, with c[k] being position k+1:
  - c[0]=p1, c[1]=p2, c[2]=d0, c[3]=p3, c[4]=d1, c[5]=d2, c[6]=d3.
  - p1=d0^d1^d3, p2=d0^d2^d3, p3=d1^d2^d3 (even parity).
- Injection: when `inj_pos`=n≠0, bit c[n-1] is inverted before it is stored in `code` and the shift register.
- Frame format: start bit 0, then c[0]..c[6] LSB first, then stop bit 1. Total 9 bits.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE → START on `in_valid && in_ready`.
  - START → DATA after BIT_CYCLES cycles.
  - DATA → STOP after 7 bit periods, tracked by a 3-bit bit index.
  - STOP → IDLE after BIT_CYCLES cycles, with a `done` pulse.
- `in_ready` = (state==IDLE) && !rst. Input is accepted only on a cycle where both `in_valid` and `in_ready` are high.
- `in_valid` while busy is ignored; nothing is queued.
- `busy` = state≠IDLE.
- `code` holds its value until the next accept.
- Bit timer: down-counter of width $clog2(BIT_CYCLES), reloaded to BIT_CYCLES-1 at each bit boundary.

## Timing
- Reset values: `tx`=1, `in_ready`=0 while `rst` is high, `code`=0, `busy`=0, `done`=0, state=IDLE.
- After `rst` deasserts, `in_ready`=1 on the first cycle.
- Accept on edge k:
  - `code`, `busy`=1 and `tx`=0 are all visible after edge k. This is a registered output with one cycle of latency.
- Each bit is held on `tx` for exactly BIT_CYCLES cycles. The full frame lasts 9·BIT_CYCLES cycles from accept.
- End of frame:
  - `done`=1 for exactly the one cycle after the last stop-bit cycle.
  - In that same cycle: state=IDLE, `in_ready`=1, `busy`=0.
  - An accept in that cycle starts the next frame with no idle gap. `tx` goes stop(1) → start(0) directly.
- Reset mid-frame:
  - The frame is aborted; `tx`=1 after the reset edge.
  - No `done` pulse; `code` is cleared to 0.
- `inj_pos` and `in_data` are don't-care on every cycle other than the accept cycle.

## Structure
- Package `ham_pkg` holds:
  - the state enum (IDLE, START, DATA, STOP);
  - `FRAME_BITS`=9 and `CODE_W`=7;
  - the parity equations as a function `ham_encode(d[3:0]) → c[6:0]`, shared with the decoder's syndrome equations so the layout has a single source.
- Sub-module `ham_encoder` is a combinational wrapper around `ham_encode` and is also reusable in the top for loopback.
- The FSM, bit timer, shift register and injection logic live in `ham_serial_tx`.

## Test plan
- Reset release:
  - Stimulus: hold `rst` for 3 cycles, then release.
  - Response: `tx`=1, `code`=0, `busy`=0 throughout. `in_ready`=0 during reset and 1 on the first cycle after.
- Encode, no injection:
  - Stimulus: BIT_CYCLES=4, `in_data`=4'b1011, `inj_pos`=0.
  - Response: `code`=7'b1010101. `tx` sequence 0,1,0,1,0,1,0,1,1, each bit 4 cycles. `done` pulses at cycle 37 after accept.
- Encode with injection:
  - Stimulus: `in_data`=4'b0001, `inj_pos`=3.
  - Response: `code`=7'b0000011. Feeding `code` to the decoder yields the syndrome for position 3.
- All-zero data:
  - Stimulus: `in_data`=0.
  - Response: `code`=0; `tx` = 0 for 8 bits, then 1.
- Back-to-back and ignored input:
  - Stimulus: hold `in_valid`=1 with 4'b1011, then 4'b0000.
  - Response: mid-frame `in_valid` is ignored. The second frame's start bit follows the first stop bit with no gap, and there is one `done` per frame.
- Reset mid-frame:
  - Stimulus: assert `rst` during DATA bit 3.
  - Response: `tx`=1 on the next cycle, no `done`, `code`=0, `busy`=0.

Source files
------------

// File: rtl/ham_pkg.sv
// ham_pkg: shared definitions for the Hamming (7,4) link.
//   - tx_state_t     : serial transmitter states
//   - FRAME_BITS     : start + 7 code bits + stop
//   - CODE_W         : codeword width
//   - ham_encode()   : nibble -> codeword (c[k] is position k+1)
//   - ham_syndrome() : codeword -> 3-bit syndrome (0 = clean, n = position n flipped)
package ham_pkg;

    localparam int FRAME_BITS = 9;
    localparam int CODE_W     = 7;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

    // Layout: p1 p2 d0 p3 d1 d2 d3 at positions 1..7, even parity.
    function automatic logic [CODE_W-1:0] ham_encode(input logic [3:0] d);
        logic [CODE_W-1:0] c;
        c[0] = d[0] ^ d[1] ^ d[3];
        c[1] = d[0] ^ d[2] ^ d[3];
        c[2] = d[0];
        c[3] = d[1] ^ d[2] ^ d[3];
        c[4] = d[1];
        c[5] = d[2];
        c[6] = d[3];
        return c;
    endfunction

    // Each syndrome bit re-checks one parity group, so a single flipped
    // position n yields syndrome value n.
    function automatic logic [2:0] ham_syndrome(input logic [CODE_W-1:0] c);
        return {c[3] ^ c[4] ^ c[5] ^ c[6],
                c[1] ^ c[2] ^ c[5] ^ c[6],
                c[0] ^ c[2] ^ c[4] ^ c[6]};
    endfunction

endpackage

// File: rtl/ham_encoder.sv
// ham_encoder: combinational Hamming (7,4) encoder.
//   i_data [3:0] : data nibble d[3:0]
//   o_code [6:0] : codeword, c[k] is position k+1
module ham_encoder
    import ham_pkg::*;
(
    input  logic [3:0]        i_data,
    output logic [CODE_W-1:0] o_code
);

    assign o_code = ham_encode(i_data);

endmodule

// File: rtl/ham_serial_tx.sv
// ham_serial_tx: encodes a nibble into a Hamming (7,4) codeword and sends it
// as a 9-bit frame (start 0, c[0]..c[6], stop 1) on a single serial line.
// Optionally flips one codeword position to exercise the remote decoder.
//   clk, rst  : clock, synchronous active-high reset
//   in_data   : nibble to encode, sampled at accept
//   in_valid  : in_data valid
//   in_ready  : block idle and out of reset
//   inj_pos   : 0 = no error, n = flip position n; sampled at accept
//   code      : codeword of the last accepted nibble (with injected error)
//   tx        : serial line, idle high
//   busy      : frame in progress
//   done      : one-cycle pulse after the stop bit completes
module ham_serial_tx
    import ham_pkg::*;
#(
    parameter int BIT_CYCLES = 2700
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        inj_pos,
    output logic [CODE_W-1:0] code,
    output logic              tx,
    output logic              busy,
    output logic              done
);

    localparam int              TW     = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam logic [TW-1:0]   RELOAD = TW'(BIT_CYCLES - 1);
    localparam logic [2:0]      LAST_BIT = 3'(CODE_W - 1);

    tx_state_t          r_state;
    tx_state_t          w_state_nxt;
    logic [TW-1:0]      r_timer;
    logic [2:0]         r_bit;
    logic [CODE_W-1:0]  r_shift;
    logic [CODE_W-1:0]  r_code;
    logic               r_tx;
    logic               r_done;

    logic [CODE_W-1:0]  w_enc;
    logic [CODE_W-1:0]  w_flip;
    logic [CODE_W-1:0]  w_cw;
    logic               w_accept;
    logic               w_tick;

    ham_encoder u_enc (
        .i_data (in_data),
        .o_code (w_enc)
    );

    // One-hot flip mask for the selected position; position 0 means none.
    assign w_flip   = (inj_pos == 3'd0) ? '0 : (CODE_W'(1) << (inj_pos - 3'd1));
    assign w_cw     = w_enc ^ w_flip;

    assign in_ready = (r_state == IDLE) && !rst;
    assign w_accept = in_valid && in_ready;
    assign w_tick   = (r_timer == '0);

    assign busy     = (r_state != IDLE);
    assign tx       = r_tx;
    assign done     = r_done;
    assign code     = r_code;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept)                   w_state_nxt = START;
            START:   if (w_tick)                     w_state_nxt = DATA;
            DATA:    if (w_tick && r_bit == LAST_BIT) w_state_nxt = STOP;
            STOP:    if (w_tick)                     w_state_nxt = IDLE;
            default:                                 w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_timer <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_code  <= '0;
            r_tx    <= 1'b1;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= 1'b0;
            // Timer counts down inside a bit and reloads on every boundary.
            if (r_state != IDLE) r_timer <= w_tick ? RELOAD : r_timer - 1'b1;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_code  <= w_cw;
                        r_shift <= w_cw;
                        r_tx    <= 1'b0;   // start bit goes out right after accept
                        r_timer <= RELOAD;
                        r_bit   <= '0;
                    end
                end
                START: begin
                    if (w_tick) begin
                        r_tx    <= r_shift[0];
                        r_shift <= r_shift >> 1;
                    end
                end
                DATA: begin
                    // r_bit is the code bit currently on the line.
                    if (w_tick) begin
                        r_tx    <= (r_bit == LAST_BIT) ? 1'b1 : r_shift[0];
                        r_shift <= r_shift >> 1;
                        r_bit   <= r_bit + 3'd1;
                    end
                end
                STOP: begin
                    if (w_tick) begin
                        r_tx   <= 1'b1;
                        r_done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
